// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - register-file write-port arbitration bus
interface rf_wb_arbiter_if #(
   parameter int AW = 2
);
   logic          pipe_wr;
   logic [4:0]    pipe_addr;
   logic [31:0]   pipe_data;
   logic          md_valid;
   logic [4:0]    md_addr;
   logic [31:0]   md_data;
   logic          md_ready;
   logic          rf_wr;
   logic [4:0]    rf_addr;
   logic [31:0]   rf_data;
   logic [4:0]    q_addr1;
   logic [4:0]    q_addr2;
   logic          q_hit1;
   logic          q_hit2;
   logic [AW:0]   count;
   logic          waw_err;

   modport master (
      output pipe_wr, pipe_addr, pipe_data, md_valid, md_addr, md_data, q_addr1, q_addr2,
      input  md_ready, rf_wr, rf_addr, rf_data, q_hit1, q_hit2, count, waw_err
   );

   modport slave (
      input  pipe_wr, pipe_addr, pipe_data, md_valid, md_addr, md_data, q_addr1, q_addr2,
      output md_ready, rf_wr, rf_addr, rf_data, q_hit1, q_hit2, count, waw_err
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - merges pipeline writeback and buffered mult/div results onto one RF write port
module rf_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic            clk,
   input  logic            reset,
   rf_wb_arbiter_if.slave  bus
);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [4:0]       ent_addr [DEPTH];
   logic [31:0]      ent_data [DEPTH];
   logic [DEPTH-1:0] ent_valid;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             waw_q;

   logic             pipe_act;
   logic             md_ready_w;
   logic             md_fire;
   logic             push;
   logic             pop;
   logic             waw_now;
   logic             hit1;
   logic             hit2;
   logic             rf_wr_w;
   logic [4:0]       rf_addr_w;
   logic [31:0]      rf_data_w;

   assign pipe_act   = bus.pipe_wr && (bus.pipe_addr != 5'd0);
   assign md_ready_w = (cnt != DEPTH_CNT);
   assign md_fire    = bus.md_valid && md_ready_w;
   // r0 results complete the handshake but are dropped: writes to r0 are architecturally void
   assign push       = md_fire && (bus.md_addr != 5'd0);
   assign pop        = !pipe_act && (cnt != '0);

   always_comb begin
      rf_wr_w   = 1'b0;
      rf_addr_w = 5'd0;
      rf_data_w = 32'd0;
      if (pipe_act) begin
         rf_wr_w   = 1'b1;
         rf_addr_w = bus.pipe_addr;
         rf_data_w = bus.pipe_data;
      end else if (cnt != '0) begin
         rf_wr_w   = 1'b1;
         rf_addr_w = ent_addr[rd_ptr];
         rf_data_w = ent_data[rd_ptr];
      end
   end

   // The head entry still hits while draining: the RF only holds it after this edge
   always_comb begin
      hit1    = 1'b0;
      hit2    = 1'b0;
      waw_now = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i]) begin
            if (ent_addr[i] == bus.q_addr1)   hit1    = 1'b1;
            if (ent_addr[i] == bus.q_addr2)   hit2    = 1'b1;
            if (ent_addr[i] == bus.pipe_addr) waw_now = 1'b1;
         end
      end
      if (md_fire) begin
         if (bus.md_addr == bus.q_addr1) hit1 = 1'b1;
         if (bus.md_addr == bus.q_addr2) hit2 = 1'b1;
      end
      if (bus.q_addr1 == 5'd0) hit1 = 1'b0;
      if (bus.q_addr2 == 5'd0) hit2 = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         ent_valid <= '0;
         waw_q     <= 1'b0;
      end else begin
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + 1'b1;
         end
         if (push) begin
            ent_valid[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (pipe_act && waw_now) waw_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[wr_ptr] <= bus.md_addr;
         ent_data[wr_ptr] <= bus.md_data;
      end
   end

   assign bus.md_ready = md_ready_w;
   assign bus.rf_wr    = rf_wr_w;
   assign bus.rf_addr  = rf_addr_w;
   assign bus.rf_data  = rf_data_w;
   assign bus.q_hit1   = hit1;
   assign bus.q_hit2   = hit2;
   assign bus.count    = cnt;
   assign bus.waw_err  = waw_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - queue-model scoreboard plus directed checks for rf_wb_arbiter
module tb_rf_wb_arbiter;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic clk;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;

   ent_t mq[$];
   logic m_waw;

   rf_wb_arbiter_if #(.AW(AW)) bus ();

   rf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic model_hit(input logic [4:0] a);
      logic h;
      h = 1'b0;
      foreach (mq[i]) if (mq[i].a == a) h = 1'b1;
      return h;
   endfunction

   // Scoreboard: expected outputs follow from the queue contents and the current inputs
   always @(negedge clk) begin
      logic       pact, e_ready, fire, e_wr, e_h1, e_h2;
      logic [4:0] e_addr;
      logic [31:0] e_data;
      if (!reset) begin
         mq.delete();
         m_waw = 1'b0;
         check("rst_count", 32'(bus.count), 0);
         check("rst_rf_wr", 32'(bus.rf_wr), 0);
         check("rst_md_ready", 32'(bus.md_ready), 1);
         check("rst_q_hit1", 32'(bus.q_hit1), 0);
         check("rst_q_hit2", 32'(bus.q_hit2), 0);
         check("rst_waw_err", 32'(bus.waw_err), 0);
      end else begin
         pact    = bus.pipe_wr && bus.pipe_addr != 0;
         e_ready = mq.size() < DEPTH;
         fire    = bus.md_valid && e_ready;
         e_wr    = pact || mq.size() > 0;
         e_addr  = pact ? bus.pipe_addr : (mq.size() > 0 ? mq[0].a : 5'd0);
         e_data  = pact ? bus.pipe_data : (mq.size() > 0 ? mq[0].d : 32'd0);
         e_h1    = bus.q_addr1 != 0 && (model_hit(bus.q_addr1) || (fire && bus.md_addr == bus.q_addr1));
         e_h2    = bus.q_addr2 != 0 && (model_hit(bus.q_addr2) || (fire && bus.md_addr == bus.q_addr2));
         check("sb_md_ready", 32'(bus.md_ready), 32'(e_ready));
         check("sb_count", 32'(bus.count), mq.size());
         check("sb_rf_wr", 32'(bus.rf_wr), 32'(e_wr));
         if (e_wr) begin
            check("sb_rf_addr", 32'(bus.rf_addr), 32'(e_addr));
            check("sb_rf_data", bus.rf_data, e_data);
         end
         check("sb_q_hit1", 32'(bus.q_hit1), 32'(e_h1));
         check("sb_q_hit2", 32'(bus.q_hit2), 32'(e_h2));
         check("sb_waw_err", 32'(bus.waw_err), 32'(m_waw));
         if (pact) begin
            if (model_hit(bus.pipe_addr)) m_waw = 1'b1;
         end else if (mq.size() > 0) begin
            void'(mq.pop_front());
         end
         if (fire && bus.md_addr != 0) mq.push_back('{a: bus.md_addr, d: bus.md_data});
      end
   end

   task automatic cyc(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] mdd,
                      input logic [4:0] q1, input logic [4:0] q2);
      @(posedge clk);
      #1;
      bus.pipe_wr   = pw;
      bus.pipe_addr = pa;
      bus.pipe_data = pd;
      bus.md_valid  = mv;
      bus.md_addr   = ma;
      bus.md_data   = mdd;
      bus.q_addr1   = q1;
      bus.q_addr2   = q2;
      @(negedge clk);
   endtask

   task automatic idle(input logic [4:0] q1);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, 5'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
      $fatal(1);
   end

   initial begin
      logic [4:0] seq [5];
      seq[0] = 5'd4; seq[1] = 5'd6; seq[2] = 5'd7; seq[3] = 5'd8; seq[4] = 5'd9;
      reset = 1'b0;
      bus.pipe_wr = 1'b0; bus.pipe_addr = 5'd0; bus.pipe_data = 32'd0;
      bus.md_valid = 1'b0; bus.md_addr = 5'd0; bus.md_data = 32'd0;
      bus.q_addr1 = 5'd0; bus.q_addr2 = 5'd0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;

      idle(5'd5);
      check("idle_rf_wr", 32'(bus.rf_wr), 0);
      check("idle_md_ready", 32'(bus.md_ready), 1);
      check("idle_count", 32'(bus.count), 0);
      check("idle_q_hit1", 32'(bus.q_hit1), 0);

      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, 5'd5, 5'd0);
      check("push_hit_same_cycle", 32'(bus.q_hit1), 1);
      check("push_rf_wr", 32'(bus.rf_wr), 0);
      idle(5'd5);
      check("drain_rf_wr", 32'(bus.rf_wr), 1);
      check("drain_rf_addr", 32'(bus.rf_addr), 5);
      check("drain_rf_data", bus.rf_data, 32'h11);
      check("drain_count", 32'(bus.count), 1);
      check("drain_still_hits", 32'(bus.q_hit1), 1);
      idle(5'd5);
      check("after_drain_count", 32'(bus.count), 0);
      check("after_drain_hit", 32'(bus.q_hit1), 0);

      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 5'd3, 32'h33, 1'b1, seq[i], 32'h100 + 32'(seq[i]), 5'd4, 5'd9);
         check("fill_rf_addr", 32'(bus.rf_addr), 3);
         check("fill_count", 32'(bus.count), i);
      end
      check("full_md_ready", 32'(bus.md_ready), 0);
      check("full_hit_r9", 32'(bus.q_hit2), 0);
      for (int i = 0; i < 4; i++) begin
         idle(5'd0);
         check("order_rf_addr", 32'(bus.rf_addr), 32'(seq[i]));
         check("order_rf_data", bus.rf_data, 32'h100 + 32'(seq[i]));
         if (i == 0) check("full_pop_no_ready", 32'(bus.md_ready), 0);
      end
      idle(5'd0);
      check("empty_rf_wr", 32'(bus.rf_wr), 0);

      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hdead, 5'd0, 5'd0);
      check("r0_md_ready", 32'(bus.md_ready), 1);
      check("r0_q_hit1", 32'(bus.q_hit1), 0);
      idle(5'd0);
      check("r0_count", 32'(bus.count), 0);
      check("r0_rf_wr", 32'(bus.rf_wr), 0);

      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0);
      cyc(1'b1, 5'd7, 32'haa, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
      check("waw_rf_data", bus.rf_data, 32'haa);
      check("waw_count", 32'(bus.count), 1);
      check("waw_hit", 32'(bus.q_hit1), 1);
      check("waw_not_yet", 32'(bus.waw_err), 0);
      idle(5'd0);
      check("waw_set", 32'(bus.waw_err), 1);
      check("waw_drain_addr", 32'(bus.rf_addr), 7);
      check("waw_drain_data", bus.rf_data, 32'h77);
      idle(5'd0);
      check("waw_sticky", 32'(bus.waw_err), 1);

      for (int i = 0; i < 3; i++) cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'(10 + i), 32'(i), 5'd0, 5'd0);
      @(posedge clk);
      #1;
      check("pre_reset_count", 32'(bus.count), 3);
      bus.pipe_wr = 1'b0; bus.md_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("async_reset_count", 32'(bus.count), 0);
      check("async_reset_rf_wr", 32'(bus.rf_wr), 0);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle(5'd10);
         check("post_reset_no_drain", 32'(bus.rf_wr), 0);
      end
      check("post_reset_waw", 32'(bus.waw_err), 0);

      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
